// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the multicycle control unit and mult_div_unit.
interface mult_div_unit_if #(parameter int unsigned WIDTH = 32);
    logic             start;
    logic             op_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op_div, a, b, input busy, done, div_zero, hi, lo);
    modport slave  (input start, op_div, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, one result bit per clock.
// Optional MULT_DIV_EARLY_EXIT_EN: a multiply with a zero operand finishes on the first RUN edge.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc, m;
    logic [WIDTH-1:0] q;
    logic             qm1, op_q, neg_q, neg_r, dz_q;
`ifdef MULT_DIV_EARLY_EXIT_EN
    logic             mz_q;
`endif

    logic             skip, last;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum, sh, diff, acc_nx;
    logic [WIDTH-1:0] q_nx, hi_fin, lo_fin;
    logic             qm1_nx;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (skip || last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
`ifdef MULT_DIV_EARLY_EXIT_EN
        skip = dz_q | mz_q;
`else
        skip = dz_q;
`endif
        last  = (cnt == CW'(WIDTH - 1));
        a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;

        // Booth step: add/subtract multiplicand, then arithmetic shift of {acc,q,qm1}
        sum = acc;
        case ({q[0], qm1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase

        // Restoring step: shift next dividend bit into the partial remainder
        sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
        diff = sh - m;

        if (op_q) begin
            acc_nx = diff[WIDTH] ? sh : diff;
            q_nx   = {q[WIDTH-2:0], ~diff[WIDTH]};
            qm1_nx = qm1;
            lo_fin = neg_q ? -q_nx : q_nx;
            hi_fin = neg_r ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
        end else begin
            acc_nx = {sum[WIDTH], sum[WIDTH:1]};
            q_nx   = {sum[0], q[WIDTH-1:1]};
            qm1_nx = q[0];
            lo_fin = q_nx;
            hi_fin = acc_nx[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            m      <= '0;
            q      <= '0;
            qm1    <= 1'b0;
            op_q   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_q   <= 1'b0;
`ifdef MULT_DIV_EARLY_EXIT_EN
            mz_q   <= 1'b0;
`endif
            bus.hi <= '0;
            bus.lo <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    cnt   <= '0;
                    acc   <= '0;
                    qm1   <= 1'b0;
                    op_q  <= bus.op_div;
                    dz_q  <= bus.op_div && (bus.b == '0);
                    neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    neg_r <= bus.a[WIDTH-1];
`ifdef MULT_DIV_EARLY_EXIT_EN
                    mz_q  <= !bus.op_div && ((bus.a == '0) || (bus.b == '0));
`endif
                    if (bus.op_div) begin
                        q <= a_mag;
                        m <= {1'b0, b_mag};
                    end else begin
                        q <= bus.b;
                        m <= {bus.a[WIDTH-1], bus.a};
                    end
                end
                RUN: begin
                    if (dz_q) begin
                        // divide by zero: results deliberately left untouched
                    end
`ifdef MULT_DIV_EARLY_EXIT_EN
                    else if (mz_q) begin
                        bus.hi <= '0;
                        bus.lo <= '0;
                    end
`endif
                    else begin
                        acc <= acc_nx;
                        q   <= q_nx;
                        qm1 <= qm1_nx;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            bus.hi <= hi_fin;
                            bus.lo <= lo_fin;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.div_zero = (state == DONE) && dz_q;
endmodule
